// File: rtl/a2_timer_divider_if.sv
// Tick and timing-pulse bundle between the timer divider and its consumers.
// The master drives the ticks and timing pulses, and the slave supplies the monitor stop.
interface a2_timer_divider_if;
  logic        mstp;
  logic        osc_tick;
  logic        p_tick;
  logic [11:0] tp_n;
  logic        mct;
  logic        fs01_n;

  modport master (
    input  mstp,
    output osc_tick,
    output p_tick,
    output tp_n,
    output mct,
    output fs01_n
  );

  modport slave (
    output mstp,
    input  osc_tick,
    input  p_tick,
    input  tp_n,
    input  mct,
    input  fs01_n
  );
endinterface

// File: rtl/a2_timer_divider.sv
// Timing source: a fractional accumulator produces the oscillator tick, which is halved to the
// phase tick that advances the 12-slot timing-pulse ring and the FS01_ square-wave divider.
module a2_timer_divider #(
  parameter int unsigned OSC_NUM = 128,
  parameter int unsigned OSC_DEN = 3125,
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned FS_HALF = 10
) (
  input  logic                  sim_clk,
  input  logic                  sim_rst,
  a2_timer_divider_if.master    bus
);

  localparam int unsigned RING_N = 12;
  localparam int unsigned FS_W   = $clog2(FS_HALF + 1);
  localparam logic [RING_N-1:0] TP_RESET = {{(RING_N-1){1'b1}}, 1'b0};

  logic [ACC_W-1:0]  acc;
  logic              div2;
  logic [FS_W-1:0]   fs_cnt;
  logic              osc_q;
  logic              p_q;
  logic              mct_q;
  logic              fs_q;
  logic [RING_N-1:0] tp_q;

  logic [ACC_W-1:0]  sum_c;
  logic              wrap_c;
  logic              p_step_c;
  logic              at_t12_c;
  logic              park_c;

  // Next accumulator value and the events it triggers this edge.
  always_comb begin
    sum_c    = acc + ACC_W'(OSC_NUM);
    wrap_c   = (sum_c >= ACC_W'(OSC_DEN));
    p_step_c = wrap_c & div2;
    at_t12_c = ~tp_q[RING_N-1];
    park_c   = at_t12_c & bus.mstp;
  end

  // The ring is held directly as the active-low one-hot pattern, so TP_ is a plain register.
  always_ff @(posedge sim_clk) begin
    if (sim_rst) begin
      acc    <= '0;
      div2   <= 1'b0;
      fs_cnt <= '0;
      osc_q  <= 1'b0;
      p_q    <= 1'b0;
      mct_q  <= 1'b0;
      fs_q   <= 1'b0;
      tp_q   <= TP_RESET;
    end else begin
      acc   <= wrap_c ? (sum_c - ACC_W'(OSC_DEN)) : sum_c;
      osc_q <= wrap_c;
      p_q   <= p_step_c;
      mct_q <= 1'b0;
      if (wrap_c) begin
        div2 <= ~div2;
      end
      if (p_step_c) begin
        // Monitor stop parks the ring on T12; FS01_ keeps dividing regardless.
        if (!park_c) begin
          tp_q <= {tp_q[RING_N-2:0], tp_q[RING_N-1]};
        end
        mct_q <= at_t12_c & ~bus.mstp;
        if (fs_cnt == FS_W'(FS_HALF - 1)) begin
          fs_cnt <= '0;
          fs_q   <= ~fs_q;
        end else begin
          fs_cnt <= fs_cnt + FS_W'(1);
        end
      end
    end
  end

  assign bus.osc_tick = osc_q;
  assign bus.p_tick   = p_q;
  assign bus.mct      = mct_q;
  assign bus.fs01_n   = fs_q;
  assign bus.tp_n     = tp_q;

endmodule

// File: tb/tb_a2_timer_divider.sv
// Bench for a2_timer_divider: an arithmetic rate model checked every cycle, plus directed
// scenarios for reset latency, long-run rates, tick spacing, monitor stop and mid-run reset.
module tb_a2_timer_divider;

  localparam longint NUM = 128;
  localparam longint DEN = 3125;
  localparam int     FSH = 10;

  logic clk;
  logic sim_rst;

  a2_timer_divider_if bus ();

  a2_timer_divider #(
    .OSC_NUM(128),
    .OSC_DEN(3125),
    .ACC_W  (12),
    .FS_HALF(10)
  ) dut (
    .sim_clk(clk),
    .sim_rst(sim_rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: wraps after k edges since reset are floor(NUM*k/DEN); every even wrap is a phase tick.
  longint k_m;
  int     tcnt_m;
  int     pcount_m;
  bit     osc_m, p_m, mct_m, model_ok;

  always @(posedge clk) begin
    if (sim_rst) begin
      k_m      = 0;
      tcnt_m   = 1;
      pcount_m = 0;
      osc_m    = 1'b0;
      p_m      = 1'b0;
      mct_m    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      longint w_now, w_prev;
      k_m++;
      w_now  = (NUM * k_m) / DEN;
      w_prev = (NUM * (k_m - 1)) / DEN;
      osc_m  = (w_now > w_prev);
      p_m    = osc_m && (w_now % 2 == 0);
      mct_m  = 1'b0;
      if (p_m) begin
        pcount_m++;
        if (tcnt_m < 12) begin
          tcnt_m++;
        end else if (!bus.mstp) begin
          tcnt_m = 1;
          mct_m  = 1'b1;
        end
      end
    end
  end

  logic prev_osc = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      logic [11:0] tp_exp;
      tp_exp = ~(12'd1 << (tcnt_m - 1));
      chk("osc_tick", 32'(bus.osc_tick), 32'(osc_m));
      chk("p_tick",   32'(bus.p_tick),   32'(p_m));
      chk("mct",      32'(bus.mct),      32'(mct_m));
      chk("tp_n",     32'(bus.tp_n),     32'(tp_exp));
      chk("fs01_n",   32'(bus.fs01_n),   32'((pcount_m / FSH) % 2));
      chk("tp_onehot", 32'($countones(~bus.tp_n)), 32'd1);
      chk("osc_consecutive", 32'(prev_osc & bus.osc_tick), 32'd0);
      prev_osc = bus.osc_tick;
    end
  end

  initial begin
    int first_osc, first_p, n_osc, n_p, n_mct, n_fs;
    int last_osc, last_p, last_fs, pc, guard, mct_seen, fs_tog;
    logic [11:0] tp_first_p;
    logic fs_prev;

    sim_rst  = 1'b1;
    bus.mstp = 1'b0;

    // T1: reset state
    repeat (5) @(negedge clk);
    chk("rst_tp",  32'(bus.tp_n), 32'h0FFE);
    chk("rst_fs",  32'(bus.fs01_n), 32'd0);
    chk("rst_osc", 32'(bus.osc_tick), 32'd0);
    chk("rst_p",   32'(bus.p_tick), 32'd0);
    chk("rst_mct", 32'(bus.mct), 32'd0);

    // T1/T2/T6: latency, long-run rates and tick spacing over 62500 edges
    sim_rst = 1'b0;
    first_osc = 0; first_p = 0; tp_first_p = '0;
    n_osc = 0; n_p = 0; n_mct = 0; n_fs = 0;
    last_osc = 0; last_p = 0; last_fs = 0;
    fs_prev = bus.fs01_n;
    for (int i = 1; i <= 62500; i++) begin
      @(negedge clk);
      if (bus.osc_tick) begin
        if (first_osc == 0) first_osc = i;
        if (last_osc != 0)
          chk("osc_gap", 32'((i - last_osc == 24) || (i - last_osc == 25)), 32'd1);
        last_osc = i;
        n_osc++;
      end
      if (bus.p_tick) begin
        if (first_p == 0) begin
          first_p    = i;
          tp_first_p = bus.tp_n;
        end
        if (last_p != 0)
          chk("p_gap", 32'((i - last_p == 48) || (i - last_p == 49)), 32'd1);
        last_p = i;
        n_p++;
      end
      if (bus.mct) n_mct++;
      if (bus.fs01_n != fs_prev) begin
        if (last_fs != 0)
          chk("fs_half", 32'((i - last_fs == 488) || (i - last_fs == 489)), 32'd1);
        last_fs = i;
        n_fs++;
      end
      fs_prev = bus.fs01_n;
    end
    chk("first_osc", 32'(first_osc), 32'd25);
    chk("first_p",   32'(first_p),   32'd49);
    chk("tp_first_p", 32'(tp_first_p), 32'h0FFD);
    chk("n_osc", 32'(n_osc), 32'd2560);
    chk("n_p",   32'(n_p),   32'd1280);
    chk("n_mct", 32'(n_mct), 32'd106);
    chk("n_fs",  32'(n_fs),  32'd128);
    chk("end_fs", 32'(bus.fs01_n), 32'd0);
    chk("end_tp", 32'(bus.tp_n), 32'h0EFF);

    // T4: monitor stop asserted at T05
    guard = 0;
    while (bus.tp_n != 12'hFEF && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_t05", 32'(bus.tp_n), 32'h0FEF);
    bus.mstp = 1'b1;
    pc = 0; guard = 0;
    while (pc < 7 && guard < 1000) begin
      @(negedge clk);
      if (bus.p_tick) pc++;
      guard++;
    end
    chk("mstp_reach_t12", 32'(bus.tp_n), 32'h07FF);
    pc = 0; guard = 0; mct_seen = 0; fs_tog = 0;
    fs_prev = bus.fs01_n;
    while (pc < 20 && guard < 2000) begin
      @(negedge clk);
      if (bus.p_tick) pc++;
      if (bus.mct) mct_seen++;
      if (bus.fs01_n != fs_prev) fs_tog++;
      fs_prev = bus.fs01_n;
      guard++;
    end
    chk("mstp_hold_tp", 32'(bus.tp_n), 32'h07FF);
    chk("mstp_no_mct", 32'(mct_seen), 32'd0);
    chk("mstp_fs_toggles", 32'(fs_tog), 32'd2);
    bus.mstp = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.p_tick && guard < 100);
    chk("mstp_release_tp", 32'(bus.tp_n), 32'h0FFE);
    chk("mstp_release_mct", 32'(bus.mct), 32'd1);

    // T5: reset mid-ring at T07 with FS01_ high
    guard = 0;
    while (!(bus.tp_n == 12'hFBF && bus.fs01_n) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_t07_fs1", 32'(bus.tp_n == 12'hFBF && bus.fs01_n), 32'd1);
    sim_rst = 1'b1;
    @(negedge clk);
    chk("midrst_tp",  32'(bus.tp_n), 32'h0FFE);
    chk("midrst_fs",  32'(bus.fs01_n), 32'd0);
    chk("midrst_osc", 32'(bus.osc_tick), 32'd0);
    chk("midrst_p",   32'(bus.p_tick), 32'd0);
    chk("midrst_mct", 32'(bus.mct), 32'd0);
    sim_rst = 1'b0;
    first_osc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.osc_tick && first_osc == 0) first_osc = i;
    end
    chk("midrst_first_osc", 32'(first_osc), 32'd25);
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
